i2c_req_arbiter: RTL and testbench
==================================

// Module: i2c_req_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one I2C wishbone-master command port among NREQ requesters.
//  Latches the winning request and launches it with a high pulse on i2c_wr; the master starts on the falling edge.
//  Tracks i2c_busy through to completion, then returns read data and a done or err pulse to the owning requester.
//  Sits between sensor/EEPROM client logic and the I2C wishbone master.
// PARAMETERS
//  NREQ      4   number of requesters (2..8)
//  IDW       2   width of gnt_id; NREQ <= 2**IDW
//  WR_PULSE  4   cycles i2c_wr is held high per launch (>=2)
//  START_TO  32  cycles allowed from i2c_wr fall to i2c_busy rise before timeout
// PORTS
//  clk           in   1         system clock
//  rst           in   1         synchronous, active-high reset
//  req           in   NREQ      per-requester request level; held until own done/err
//  req_addr      in   8*NREQ    I2C address byte incl. R/W bit; requester k at [8k+7:8k]
//  req_wrdata    in   24*NREQ   write bytes {d3,d2,d1}; requester k at [24k+23:24k]
//  req_num       in   8*NREQ    byte count, valid 1..3; requester k at [8k+7:8k]
//  done          out  NREQ      1-cycle pulse, transaction finished for requester k
//  err           out  NREQ      1-cycle pulse, request rejected or timed out
//  rddata        out  24        {rd3,rd2,rd1}; valid in the done cycle, held until next done
//  gnt_valid     out  1         a transaction is owned (LOAD..COMPLETE)
//  gnt_id        out  IDW       index of current or last owner
//  i2c_wr        out  1         launch strobe to master
//  i2c_addr, i2c_wrdata1/2/3, i2c_data_num  out 8 each   latched command to master
//  i2c_busy      in   1         master busy
//  i2c_rddata1/2/3  in 8 each   master read bytes
// BEHAVIOUR
//  Reset: state=IDLE; i2c_wr, done, err, gnt_valid = 0; gnt_id, rddata, all i2c_* command outputs = 0.
//   Round-robin pointer = 0 (requester 0 highest priority).
//  States: IDLE -> LOAD -> STROBE -> WAIT_START -> WAIT_DONE -> COMPLETE -> IDLE.
//  IDLE: if |req, pick the first asserted index searching from ptr upward with wrap; go to LOAD.
//   No request -> stay in IDLE.
//  LOAD (1 cycle): latch winner's addr/wrdata/num onto i2c_* outputs; gnt_valid=1; gnt_id=winner; ptr=winner+1 mod NREQ.
//   num==0 or num>3: pulse err[winner] next cycle, no i2c_wr, back to IDLE.
//   Otherwise -> STROBE.
//  STROBE: i2c_wr=1 for exactly WR_PULSE cycles, then 0 -> WAIT_START, timeout counter cleared.
//  WAIT_START: i2c_busy=1 -> WAIT_DONE.
//   Counter reaches START_TO first -> err[winner] pulse, IDLE.
//  WAIT_DONE: wait for i2c_busy=0 (no timeout; master always terminates) -> COMPLETE.
//  COMPLETE (1 cycle): rddata <= {i2c_rddata3,i2c_rddata2,i2c_rddata1}; done[winner]=1; gnt_valid=0; -> IDLE.
//   rddata updates for writes too (don't-care content).
//  Command outputs stay stable from LOAD until the next LOAD; the master may sample them at any time while busy.
//  Inputs are sampled only in LOAD: later changes to req_* have no effect on the transaction in flight.
//  Owner drops req mid-transaction: transaction still completes and done still pulses.
//  Non-owner req rising or falling while busy: evaluated only at next IDLE.
//  At most one done/err bit set per cycle; done and err never coincide.
//  Minimum turnaround between back-to-back grants: 1 IDLE cycle after COMPLETE.
//  Reset in any state: next cycle all outputs at reset values, transaction abandoned; master is reset by the same system reset.
// TESTING
//  1 req[0], addr=A0, wrdata=xx2211, num=2; BFM busy for 50 cyc -> i2c_wr high 4 cyc, i2c_addr=A0,
//    wrdata1=11, wrdata2=22, num=02; done[0] 1 cyc after busy falls.
//  2 req[2], addr=A1, num=3; BFM returns 5A,6B,7C -> done[2] with rddata=7C6B5A, gnt_id=2.
//  3 req=1011 simultaneously -> grants 0,1,3 in order; then req=0011 -> grants 0,1 (pointer wrapped); no starvation.
//  4 req[1] with num=0 (and separately num=4) -> err[1] pulse, i2c_wr never rises, gnt_valid back to 0.
//  5 BFM never raises busy -> err[0] exactly START_TO cycles after i2c_wr falls; pending req[1] then served normally.
//  6 rst asserted in WAIT_DONE -> next cycle i2c_wr=0, gnt_valid=0, done=err=0, ptr=0; fresh req[3] after reset completes.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C wishbone-master command port among NREQ requesters,
// launching each granted transaction and returning read data plus a done/err pulse to its owner.
module i2c_req_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned WR_PULSE = 4,
  parameter int unsigned START_TO = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [8*NREQ-1:0]    req_addr_i,
  input  logic [24*NREQ-1:0]   req_wrdata_i,
  input  logic [8*NREQ-1:0]    req_num_i,
  output logic [NREQ-1:0]      done_o,
  output logic [NREQ-1:0]      err_o,
  output logic [23:0]          rddata_o,
  output logic                 gnt_valid_o,
  output logic [IDW-1:0]       gnt_id_o,
  output logic                 i2c_wr_o,
  output logic [7:0]           i2c_addr_o,
  output logic [7:0]           i2c_wrdata1_o,
  output logic [7:0]           i2c_wrdata2_o,
  output logic [7:0]           i2c_wrdata3_o,
  output logic [7:0]           i2c_data_num_o,
  input  logic                 i2c_busy_i,
  input  logic [7:0]           i2c_rddata1_i,
  input  logic [7:0]           i2c_rddata2_i,
  input  logic [7:0]           i2c_rddata3_i
);

  localparam int unsigned CntW = $clog2(START_TO + WR_PULSE + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStrobe, StWaitStart, StWaitDone, StComplete
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [NREQ-1:0] done_q, err_q;
  logic [23:0]     rddata_q;
  logic            gnt_valid_q;
  logic [IDW-1:0]  gnt_id_q;
  logic            wr_q;
  logic [7:0]      addr_q, num_q;
  logic [23:0]     wrdata_q;

  logic            win_found;
  logic [IDW-1:0]  win_idx, cand;
  logic [NREQ-1:0] owner_oh;

  assign owner_oh = NREQ'(1) << gnt_id_q;

  // First asserted request at or after ptr_q, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(ptr_q) + i >= NREQ) cand = IDW'(32'(ptr_q) + i - NREQ);
      else                        cand = IDW'(32'(ptr_q) + i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rddata_q    <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      num_q       <= '0;
      wrdata_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state_q)
        StIdle: begin
          // Skip the cycle an err is being reported so the owner can drop its request.
          if (win_found && !(|err_q)) begin
            state_q     <= StLoad;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= win_idx;
            ptr_q       <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            addr_q      <= req_addr_i[8*win_idx +: 8];
            wrdata_q    <= req_wrdata_i[24*win_idx +: 24];
            num_q       <= req_num_i[8*win_idx +: 8];
          end
        end
        StLoad: begin
          if (num_q == 8'd0 || num_q > 8'd3) begin
            err_q       <= owner_oh;
            gnt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            wr_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= StStrobe;
          end
        end
        StStrobe: begin
          if (cnt_q == CntW'(WR_PULSE - 1)) begin
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StWaitStart;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitStart: begin
          if (i2c_busy_i) begin
            state_q <= StWaitDone;
          end else if (cnt_q == CntW'(START_TO - 1)) begin
            err_q       <= owner_oh;
            gnt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!i2c_busy_i) begin
            rddata_q <= {i2c_rddata3_i, i2c_rddata2_i, i2c_rddata1_i};
            done_q   <= owner_oh;
            state_q  <= StComplete;
          end
        end
        StComplete: begin
          gnt_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done_o         = done_q;
  assign err_o          = err_q;
  assign rddata_o       = rddata_q;
  assign gnt_valid_o    = gnt_valid_q;
  assign gnt_id_o       = gnt_id_q;
  assign i2c_wr_o       = wr_q;
  assign i2c_addr_o     = addr_q;
  assign i2c_wrdata1_o  = wrdata_q[7:0];
  assign i2c_wrdata2_o  = wrdata_q[15:8];
  assign i2c_wrdata3_o  = wrdata_q[23:16];
  assign i2c_data_num_o = num_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a small master BFM answers each launch and every
// outcome is compared against hand-computed values.
module tb_i2c_req_arbiter;

  localparam int unsigned WrPulse = 4;
  localparam int unsigned StartTo = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req;
  logic [7:0]  a_addr [4];
  logic [23:0] a_wd   [4];
  logic [7:0]  a_num  [4];
  logic [31:0] req_addr, req_num;
  logic [95:0] req_wrdata;
  logic [3:0]  done, err;
  logic [23:0] rddata;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        i2c_wr, busy;
  logic [7:0]  i2c_addr, wd1, wd2, wd3, dnum, rd1, rd2, rd3;

  int n_vec;
  int n_err;

  assign req_addr   = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
  assign req_wrdata = {a_wd[3], a_wd[2], a_wd[1], a_wd[0]};
  assign req_num    = {a_num[3], a_num[2], a_num[1], a_num[0]};

  i2c_req_arbiter #(
    .NREQ(4), .IDW(2), .WR_PULSE(WrPulse), .START_TO(StartTo)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr),
    .req_wrdata_i(req_wrdata), .req_num_i(req_num), .done_o(done), .err_o(err),
    .rddata_o(rddata), .gnt_valid_o(gnt_valid), .gnt_id_o(gnt_id), .i2c_wr_o(i2c_wr),
    .i2c_addr_o(i2c_addr), .i2c_wrdata1_o(wd1), .i2c_wrdata2_o(wd2), .i2c_wrdata3_o(wd3),
    .i2c_data_num_o(dnum), .i2c_busy_i(busy), .i2c_rddata1_i(rd1), .i2c_rddata2_i(rd2),
    .i2c_rddata3_i(rd3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the launch of requester id, answer it as the master, check the completion.
  task automatic serve(input int id, input int busy_cyc, input logic [23:0] rd);
    int n;
    n = 0;
    while (!i2c_wr && n < 20) begin tick(); n++; end
    check_eq("wr_rise", 32'(i2c_wr), 1);
    check_eq("gnt_id", 32'(gnt_id), id);
    check_eq("gnt_valid", 32'(gnt_valid), 1);
    check_eq("cmd_addr", 32'(i2c_addr), 32'(a_addr[id]));
    check_eq("cmd_wd", {8'h0, wd3, wd2, wd1}, 32'(a_wd[id]));
    check_eq("cmd_num", 32'(dnum), 32'(a_num[id]));
    n = 0;
    while (i2c_wr && n < 20) begin tick(); n++; end
    check_eq("wr_width", n, WrPulse);
    {rd3, rd2, rd1} = rd;
    tick();
    tick();
    busy = 1'b1;
    repeat (busy_cyc) tick();
    busy = 1'b0;
    tick();
    check_eq("done", 32'(done), 32'(4'b0001 << id));
    check_eq("rddata", 32'(rddata), 32'(rd));
    check_eq("gv_complete", 32'(gnt_valid), 1);
    req[id] = 1'b0;
    tick();
    check_eq("done_pulse", 32'(done), 0);
    check_eq("gv_idle", 32'(gnt_valid), 0);
  endtask

  initial begin
    int n;
    logic wr_seen;
    n_vec = 0;
    n_err = 0;
    req   = '0;
    busy  = 1'b0;
    {rd3, rd2, rd1} = '0;
    for (int k = 0; k < 4; k++) begin
      a_addr[k] = 8'h0;
      a_wd[k]   = 24'h0;
      a_num[k]  = 8'h1;
    end

    // Reset state
    repeat (3) tick();
    check_eq("rst_gv", 32'(gnt_valid), 0);
    check_eq("rst_wr", 32'(i2c_wr), 0);
    check_eq("rst_done_err", {24'h0, done, err}, 0);
    check_eq("rst_gid", 32'(gnt_id), 0);
    check_eq("rst_cmd", {i2c_addr, wd1, wd2, dnum}, 0);
    check_eq("rst_rd", 32'(rddata), 0);
    rst = 1'b0;
    tick();

    // 1: write of two bytes from requester 0, long busy
    a_addr[0] = 8'hA0; a_wd[0] = 24'h332211; a_num[0] = 8'h02;
    req[0] = 1'b1;
    serve(0, 50, 24'h000000);
    check_eq("t1_wd1", 32'(wd1), 32'h11);
    check_eq("t1_wd2", 32'(wd2), 32'h22);

    // 2: three-byte read from requester 2
    a_addr[2] = 8'hA1; a_wd[2] = 24'h0; a_num[2] = 8'h03;
    req[2] = 1'b1;
    serve(2, 10, 24'h7C6B5A);

    // 3: round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      a_addr[k] = 8'h40 + 8'(k); a_wd[k] = 24'h100000 * 24'(k + 1); a_num[k] = 8'h1;
    end
    req = 4'b1011;
    serve(0, 3, 24'h000101);
    serve(1, 3, 24'h000202);
    serve(3, 3, 24'h000303);
    req = 4'b0011;
    serve(0, 3, 24'h000404);
    req[0] = 1'b1;
    serve(1, 3, 24'h000505);
    serve(0, 3, 24'h000606);

    // 4: invalid byte counts are rejected without a launch
    for (int t = 0; t < 2; t++) begin
      a_num[1] = (t == 0) ? 8'd0 : 8'd4;
      req[1] = 1'b1;
      wr_seen = 1'b0;
      n = 0;
      while (err == 4'b0 && n < 10) begin tick(); n++; wr_seen |= i2c_wr; end
      check_eq("bad_err", 32'(err), 32'b0010);
      check_eq("bad_nowr", 32'(wr_seen), 0);
      check_eq("bad_gid", 32'(gnt_id), 1);
      req[1] = 1'b0;
      tick();
      check_eq("bad_pulse", 32'(err), 0);
      check_eq("bad_gv", 32'(gnt_valid), 0);
    end

    // 5: master never starts; requester 1 is served afterwards
    a_num[1] = 8'h2;
    req = 4'b0011;
    n = 0;
    while (!i2c_wr && n < 20) begin tick(); n++; end
    check_eq("to_wr", 32'(i2c_wr), 1);
    check_eq("to_gid", 32'(gnt_id), 0);
    n = 0;
    while (i2c_wr && n < 20) begin tick(); n++; end
    n = 0;
    while (err == 4'b0 && n < 100) begin tick(); n++; end
    check_eq("to_cycles", n, StartTo);
    check_eq("to_err", 32'(err), 32'b0001);
    check_eq("to_done", 32'(done), 0);
    req[0] = 1'b0;
    serve(1, 4, 24'h0A0B0C);

    // 6: reset in the middle of a transaction
    req[2] = 1'b1;
    n = 0;
    while (!i2c_wr && n < 20) begin tick(); n++; end
    n = 0;
    while (i2c_wr && n < 20) begin tick(); n++; end
    busy = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    req = '0;
    busy = 1'b0;
    tick();
    check_eq("mid_rst_wr", 32'(i2c_wr), 0);
    check_eq("mid_rst_gv", 32'(gnt_valid), 0);
    check_eq("mid_rst_de", {24'h0, done, err}, 0);
    check_eq("mid_rst_cmd", {gnt_id, i2c_addr, dnum}, 0);
    rst = 1'b0;
    tick();
    // Pointer back at 0: requester 1 wins over 3
    req = 4'b1010;
    serve(1, 2, 24'h112233);
    serve(3, 2, 24'h445566);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
